serial_subtractor: RTL and testbench

Bit-serial unsigned/two's-complement subtractor computing diff = a - b, LSB first, one bit per clock, with a borrow flip-flop. It is the subtract-direction counterpart of the team's parallel adders, for area-constrained datapaths that can tolerate multi-cycle latency. A start/busy/done handshake sequences it, and results are held until the next operation.

---
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             borrow,
    output logic             ovf
`else
    output logic             borrow
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } stateT;

    stateT            r_state;
    stateT            w_nextState;

    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_borrow;

    logic             w_bit;
    logic             w_brNext;
    logic             w_lastBit;
    logic [WIDTH-1:0] w_resNext;

    // One full-subtractor slice, reused on every SHIFT cycle.
    assign w_bit     = r_aSh[0] ^ r_bSh[0] ^ r_br;
    assign w_brNext  = (~r_aSh[0] & r_bSh[0]) | (~(r_aSh[0] ^ r_bSh[0]) & r_br);
    assign w_lastBit = (r_cnt == LAST_CNT);
    assign w_resNext = {w_bit, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_lastBit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Visible results are written only on the final SHIFT edge, so they hold across operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aSh    <= '0;
            r_bSh    <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_borrow <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_aSh <= a;
                r_bSh <= b;
                r_br  <= 1'b0;
                r_cnt <= '0;
            end
        end else if (r_state == SHIFT) begin
            r_aSh <= r_aSh >> 1;
            r_bSh <= r_bSh >> 1;
            r_br  <= w_brNext;
            r_res <= w_resNext;
            r_cnt <= r_cnt + CW'(1);
            if (w_lastBit) begin
                r_diff   <= w_resNext;
                r_borrow <= w_brNext;
            end
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;

`ifdef SERIAL_SUB_OVF_EN
    logic [1:0] r_msbs;
    logic       r_ovf;

    // Operand sign bits are kept aside because the shift registers lose them early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msbs <= 2'b00;
            r_ovf  <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_msbs <= {a[WIDTH-1], b[WIDTH-1]};
            end
        end else if (r_state == SHIFT && w_lastBit) begin
            r_ovf <= (r_msbs[1] != r_msbs[0]) && (w_bit != r_msbs[1]);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, exhaustive shuffled WIDTH=4 sweep, WIDTH=8 spot checks.
// Expected values come from plain integer arithmetic on a and b.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow4;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf4;
    logic       ovf8;
`endif

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .start  (start4),
        .a      (a4),
        .b      (b4),
        .busy   (busy4),
        .done   (done4),
        .diff   (diff4),
`ifdef SERIAL_SUB_OVF_EN
        .borrow (borrow4),
        .ovf    (ovf4)
`else
        .borrow (borrow4)
`endif
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
`ifdef SERIAL_SUB_OVF_EN
        .borrow (borrow8),
        .ovf    (ovf8)
`else
        .borrow (borrow8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {borrow,diff} is a - b reduced modulo 2^(w+1).
    function automatic logic [8:0] refSub(input int w, input int x, input int y);
        int r;
        r = (x - y) & ((1 << (w + 1)) - 1);
        return r[8:0];
    endfunction

    function automatic logic refOvf(input int w, input int x, input int y);
        int half, sx, sy, sd;
        half = 1 << (w - 1);
        sx   = (x >= half) ? x - 2 * half : x;
        sy   = (y >= half) ? y - 2 * half : y;
        sd   = sx - sy;
        return (sd < -half) || (sd >= half);
    endfunction

    function automatic logic [8:0] curResult(input bit wide);
        return wide ? {borrow8, diff8} : {4'b0000, borrow4, diff4};
    endfunction

    function automatic logic curBusy(input bit wide);
        return wide ? busy8 : busy4;
    endfunction

    function automatic logic curDone(input bit wide);
        return wide ? done8 : done4;
    endfunction

`ifdef SERIAL_SUB_OVF_EN
    function automatic logic curOvf(input bit wide);
        return wide ? ovf8 : ovf4;
    endfunction
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Starts one operation at a negedge and walks forward until done, with a cycle bound.
    task automatic applyStimulus(input bit wide, input logic [7:0] opA, input logic [7:0] opB, input bit poke,
                                 output int busyCycles, output int doneCycle, output int holdErrs);
        logic [8:0] held;
        held = curResult(wide);
        if (wide) begin
            start8 = 1'b1;
            a8     = opA;
            b8     = opB;
        end else begin
            start4 = 1'b1;
            a4     = opA[3:0];
            b4     = opB[3:0];
        end
        @(negedge clk);
        start4     = 1'b0;
        start8     = 1'b0;
        busyCycles = 0;
        doneCycle  = 0;
        holdErrs   = 0;
        for (int i = 1; i <= 40 && doneCycle == 0; i++) begin
            if (curBusy(wide)) busyCycles++;
            if (curDone(wide)) begin
                doneCycle = i;
            end else begin
                if (curResult(wide) !== held) holdErrs++;
                if (poke && i == 2) begin
                    start4 = 1'b1;
                    a4     = ~opA[3:0];
                    b4     = 4'h5;
                end
                if (poke && i == 3) start4 = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic doOp(input bit wide, input int x, input int y, input bit poke);
        int    w, bc, dc, he;
        string id;
        w  = wide ? 8 : 4;
        id = $sformatf("w%0d %0d-%0d", w, x, y);
        applyStimulus(wide, 8'(x), 8'(y), poke, bc, dc, he);
        checkOutput({id, " doneCycle"}, dc, w + 1);
        checkOutput({id, " busyCycles"}, bc, w);
        checkOutput({id, " holdDuringShift"}, he, 0);
        checkOutput({id, " result"}, curResult(wide), refSub(w, x, y));
`ifdef SERIAL_SUB_OVF_EN
        checkOutput({id, " ovf"}, curOvf(wide), refOvf(w, x, y));
`endif
        @(negedge clk);
        checkOutput({id, " donePulseEnds"}, curDone(wide), 0);
        checkOutput({id, " idleAfterDone"}, curBusy(wide), 0);
        checkOutput({id, " resultHeld"}, curResult(wide), refSub(w, x, y));
    endtask

    initial begin
        int off, mul, p;
        bit doneSeen;
        rst    = 1'b1;
        start4 = 1'b0;
        start8 = 1'b0;
        a4     = '0;
        b4     = '0;
        a8     = '0;
        b8     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", busy4, 0);
        checkOutput("reset done", done4, 0);
        checkOutput("reset result", curResult(0), 0);
        checkOutput("reset result w8", curResult(1), 0);
        rst = 1'b0;
        @(negedge clk);

        doOp(0, 7, 3, 0);
        checkOutput("7-3 diff", diff4, 4);
        doOp(0, 3, 7, 0);
        checkOutput("3-7 diff", diff4, 12);
        checkOutput("3-7 borrow", borrow4, 1);
        doOp(0, 8, 1, 0);
        checkOutput("8-1 diff", diff4, 7);
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("8-1 ovf", ovf4, 1);
`endif

        // Abort mid-operation: outputs must clear asynchronously and no done may appear.
        start4 = 1'b1;
        a4     = 4'd9;
        b4     = 4'd2;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midop busy", busy4, 1);
        rst = 1'b1;
        #1;
        checkOutput("abort busy", busy4, 0);
        checkOutput("abort done", done4, 0);
        checkOutput("abort result", curResult(0), 0);
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("abort ovf", ovf4, 0);
`endif
        doneSeen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done4) doneSeen = 1'b1;
        end
        rst = 1'b0;
        @(negedge clk);
        if (done4) doneSeen = 1'b1;
        checkOutput("abort no done", doneSeen, 0);
        doOp(0, 9, 2, 0);
        checkOutput("9-2 diff", diff4, 7);

        // Back-to-back with start pokes while busy; second op is issued at the first IDLE negedge.
        doOp(0, 15, 15, 1);
        doOp(0, 0, 0, 1);
        checkOutput("0-0 borrow", borrow4, 0);

        off = int'($urandom_range(0, 255));
        mul = int'($urandom_range(0, 127)) * 2 + 1;
        for (int i = 0; i < 256; i++) begin
            p = (i * mul + off) & 255;
            doOp(0, p >> 4, p & 15, i[4]);
        end

        doOp(1, 0, 255, 0);
        doOp(1, 255, 0, 0);
        doOp(1, 128, 1, 0);
        doOp(1, 127, 255, 0);
        for (int i = 0; i < 8; i++) begin
            doOp(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
